db_multi: RTL



---
 rtl/db_pkg.sv | 23 ++
 rtl/db_chan.sv | 112 +++++++++++
 rtl/db_multi.sv | 49 ++++
 3 files changed

// File: rtl/db_pkg.sv
// Shared constants and the counter-width helper for the multi-channel debouncer.
// Include the long-press hold counters by defining DB_MULTI_LONGPRESS_EN.
package db_pkg;

    localparam int DB_STABLE_100MHZ = 262144;
    localparam int DB_LONG_100MHZ   = 50000000;

    // Ceiling log2, so that db_clog2(n + 1) bits can hold the values 0..n.
    function automatic int db_clog2(input longint unsigned value);
        int              width;
        longint unsigned rem;
        width = 0;
        rem   = (value == 0) ? 0 : value - 1;
        for (int i = 0; i < 64; i++) begin
            if (rem != 0) begin
                width = width + 1;
                rem   = rem >> 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/db_chan.sv
// One debounced channel: 2-FF synchroniser, stability counter, level, and press/release strobes.
// Define DB_MULTI_LONGPRESS_EN to add the saturating hold counter that drives long_press_o.
module db_chan
    import db_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_100MHZ
`ifdef DB_MULTI_LONGPRESS_EN
    ,
    parameter int LONG_CYCLES   = DB_LONG_100MHZ
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    localparam int               CNT_W    = db_clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronised input matches the level restarts the count.
    always_comb begin
        s1_d      = btn_i;
        s2_d      = s1_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d   = s2_q;
            cnt_d     = '0;
            press_d   = s2_q;
            release_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef DB_MULTI_LONGPRESS_EN
    localparam int                HOLD_W    = db_clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Saturation at HOLD_MAX keeps the strobe from repeating until level drops.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
            hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
            hold_d = HOLD_MAX;
            long_d = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/db_multi.sv
// Multi-channel button debouncer: polarity normalisation plus one db_chan per input.
// Define DB_MULTI_LONGPRESS_EN to enable long_press; release is a reserved word, so that port is named release_.
module db_multi
    import db_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = DB_STABLE_100MHZ,
    parameter int ACTIVE_LOW    = 0,
    parameter int LONG_CYCLES   = DB_LONG_100MHZ
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_,
    output logic [CHANNELS-1:0] long_press
);

    logic [CHANNELS-1:0] btn_x;

    // Everything downstream of this point is active-high.
    assign btn_x = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    generate
        if (CHANNELS < 1 || STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
            $error("db_multi: CHANNELS, STABLE_CYCLES and LONG_CYCLES must all be >= 1");
        end

        for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
            db_chan #(
                .STABLE_CYCLES (STABLE_CYCLES)
`ifdef DB_MULTI_LONGPRESS_EN
                ,
                .LONG_CYCLES   (LONG_CYCLES)
`endif
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .btn_i        (btn_x[i]),
                .level_o      (level[i]),
                .press_o      (press[i]),
                .release_o    (release_[i]),
                .long_press_o (long_press[i])
            );
        end
    endgenerate

endmodule
